// File: rtl/dbus_responder_if.sv
// dbus_responder_if: core data-port bus between the unicycle core (master) and the data responder (slave).
interface dbus_responder_if #(
    parameter int W = 32
);
    logic [W-1:0] DataAddress_i;
    logic [W-1:0] DataOut_i;
    logic [W-1:0] DataIn_o;
    logic         we_i;
    logic         read_i;
    modport master (output DataAddress_i, DataOut_i, we_i, read_i, input DataIn_o);
    modport slave  (input DataAddress_i, DataOut_i, we_i, read_i, output DataIn_o);
endinterface

// File: rtl/dbus_responder.sv
// dbus_responder: decodes core data accesses into word RAM, GPIO and a compare timer; loads return same cycle.
module dbus_responder #(
    parameter int           W         = 32,
    parameter int           RAM_WORDS = 256,
    parameter logic [W-1:0] RAM_BASE  = 'h1000,
    parameter logic [W-1:0] IO_BASE   = 'h2000,
    parameter int           GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    dbus_responder_if.slave   bus,
    input  logic [GPIO_W-1:0] sw_i,
    output logic [GPIO_W-1:0] led_o,
    output logic              irq_o
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [W-1:0]      r_ram [RAM_WORDS];
    logic [GPIO_W-1:0] r_led;
    logic [GPIO_W-1:0] r_sw_meta;
    logic [GPIO_W-1:0] r_sw_sync;
    logic [W-1:0]      r_tcount;
    logic [W-1:0]      r_tcmp;
    logic [1:0]        r_tctrl;
    logic              r_match;

    logic [W-1:0]  w_ram_off;
    logic [W-1:0]  w_io_off;
    logic [W-1:0]  w_io_rd;
    logic [AW-1:0] w_ram_idx;
    logic [2:0]    w_io_sel;
    logic          w_ram_hit;
    logic          w_io_hit;
    logic          w_hw_match;
    logic          w_wr_led;
    logic          w_wr_tcount;
    logic          w_wr_tcmp;
    logic          w_wr_tctrl;
    logic          w_wr_tstat;

    // Offsets are taken relative to each window; the low two address bits never select anything.
    assign w_ram_off = bus.DataAddress_i - RAM_BASE;
    assign w_io_off  = bus.DataAddress_i - IO_BASE;
    assign w_ram_idx = w_ram_off[AW+1:2];
    assign w_io_sel  = w_io_off[4:2];
    assign w_ram_hit = (bus.DataAddress_i >= RAM_BASE) && (w_ram_off[W-1:AW+2] == '0);
    assign w_io_hit  = (bus.DataAddress_i >= IO_BASE) && (w_io_off[W-1:5] == '0) && (w_io_sel < 3'd6);

    assign w_wr_led    = bus.we_i && w_io_hit && (w_io_sel == 3'd0);
    assign w_wr_tcount = bus.we_i && w_io_hit && (w_io_sel == 3'd2);
    assign w_wr_tcmp   = bus.we_i && w_io_hit && (w_io_sel == 3'd3);
    assign w_wr_tctrl  = bus.we_i && w_io_hit && (w_io_sel == 3'd4);
    assign w_wr_tstat  = bus.we_i && w_io_hit && (w_io_sel == 3'd5);

    assign w_hw_match = r_tctrl[0] && (r_tcount == r_tcmp);

    always_comb begin
        w_io_rd = (w_io_sel == 3'd0) ? W'(r_led) :
                  (w_io_sel == 3'd1) ? W'(r_sw_sync) :
                  (w_io_sel == 3'd2) ? r_tcount :
                  (w_io_sel == 3'd3) ? r_tcmp :
                  (w_io_sel == 3'd4) ? W'(r_tctrl) :
                  (w_io_sel == 3'd5) ? W'(r_match) : '0;
        bus.DataIn_o = !bus.read_i ? '0 :
                       w_ram_hit   ? r_ram[w_ram_idx] :
                       w_io_hit    ? w_io_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (bus.we_i && w_ram_hit) r_ram[w_ram_idx] <= bus.DataOut_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_tcount  <= '0;
            r_tcmp    <= '0;
            r_tctrl   <= '0;
            r_match   <= 1'b0;
        end else begin
            r_sw_meta <= sw_i;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) r_led <= bus.DataOut_i[GPIO_W-1:0];
            if (w_wr_tcmp) r_tcmp <= bus.DataOut_i;
            if (w_wr_tctrl) r_tctrl <= bus.DataOut_i[1:0];
            // Software count writes beat both the compare clear and the increment.
            r_tcount <= w_wr_tcount ? bus.DataOut_i :
                        w_hw_match  ? '0 :
                        r_tctrl[0]  ? r_tcount + W'(1) : r_tcount;
            r_match  <= w_hw_match | (r_match & ~(w_wr_tstat & bus.DataOut_i[0]));
        end
    end

    assign led_o = r_led;
    assign irq_o = r_match & r_tctrl[1];
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed stimulus with a per-cycle reference model plus hand-computed spot checks.
module tb_dbus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw_i = '0;
    logic [15:0] led_o;
    logic        irq_o;
    int          checks = 0;
    int          errors = 0;

    dbus_responder_if #(.W(32)) bus ();

    dbus_responder #(.W(32), .RAM_WORDS(256), .RAM_BASE(32'h1000), .IO_BASE(32'h2000), .GPIO_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .sw_i  (sw_i),
        .led_o (led_o),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: a sparse memory plus the architectural register values.
    logic [31:0] m_ram [int];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_tcount, m_tcmp;
    logic        m_en, m_ie, m_match;

    function automatic logic m_read(input logic [31:0] a, output logic [31:0] v);
        int off;
        v = 32'h0;
        if (a >= 32'h1000 && a < 32'h1400) begin
            off = int'((a - 32'h1000) / 4);
            if (!m_ram.exists(off)) return 1'b0;
            v = m_ram[off];
        end else if (a >= 32'h2000 && a < 32'h2018) begin
            case ((a - 32'h2000) / 4)
                0: v = {16'h0, m_led};
                1: v = {16'h0, m_sw2};
                2: v = m_tcount;
                3: v = m_tcmp;
                4: v = {30'h0, m_ie, m_en};
                default: v = {31'h0, m_match};
            endcase
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_led = 0; m_sw1 = 0; m_sw2 = 0; m_tcount = 0; m_tcmp = 0;
        m_en = 0; m_ie = 0; m_match = 0;
    endtask

    initial m_reset();
    always @(negedge rst) m_reset();

    always @(posedge clk) begin
        logic [31:0] a, d, reg_idx;
        logic hit, we;
        if (!rst) m_reset();
        else begin
            a = bus.DataAddress_i;
            d = bus.DataOut_i;
            we = bus.we_i;
            hit = m_en && (m_tcount == m_tcmp);
            reg_idx = (a >= 32'h2000 && a < 32'h2018) ? (a - 32'h2000) / 4 : 32'hFF;
            if (we && a >= 32'h1000 && a < 32'h1400) m_ram[int'((a - 32'h1000) / 4)] = d;
            if (we && reg_idx == 2) m_tcount = d;
            else if (hit) m_tcount = 0;
            else if (m_en) m_tcount = m_tcount + 1;
            if (hit) m_match = 1;
            else if (we && reg_idx == 5 && d[0]) m_match = 0;
            if (we && reg_idx == 0) m_led = d[15:0];
            if (we && reg_idx == 3) m_tcmp = d;
            if (we && reg_idx == 4) begin m_en = d[0]; m_ie = d[1]; end
            m_sw2 = m_sw1;
            m_sw1 = sw_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Single compare process against the model, mid-cycle.
    always @(negedge clk) begin
        logic [31:0] v;
        logic known;
        known = m_read(bus.DataAddress_i, v);
        if (!bus.read_i) chk("model_rdata_idle", bus.DataIn_o, 32'h0);
        else if (known) chk("model_rdata", bus.DataIn_o, v);
        chk("model_led", {16'h0, led_o}, {16'h0, m_led});
        chk("model_irq", {31'h0, irq_o}, {31'h0, m_match & m_ie});
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rd);
        @(posedge clk);
        #1;
        bus.DataAddress_i = a;
        bus.DataOut_i = d;
        bus.we_i = we;
        bus.read_i = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.DataAddress_i = 32'h2008;
        bus.DataOut_i = 0;
        bus.we_i = 0;
        bus.read_i = 1;
        repeat (2) @(negedge clk);
        chk("reset_led", {16'h0, led_o}, 32'h0);
        chk("reset_irq", {31'h0, irq_o}, 32'h0);
        chk("reset_tcount", bus.DataIn_o, 32'h0);
        @(posedge clk); #1 rst = 1;

        drive(32'h1010, 32'hDEADBEEF, 1, 0);
        drive(32'h1010, 0, 0, 1);
        @(negedge clk) chk("ram_load", bus.DataIn_o, 32'hDEADBEEF);
        drive(32'h1010, 0, 0, 0);
        @(negedge clk) chk("ram_noread", bus.DataIn_o, 32'h0);
        drive(32'h1010, 32'h11111111, 1, 1);
        @(negedge clk) chk("ram_rw_prewrite", bus.DataIn_o, 32'hDEADBEEF);
        drive(32'h1010, 0, 0, 1);
        @(negedge clk) chk("ram_rw_after", bus.DataIn_o, 32'h11111111);
        drive(32'h13FC, 32'hCAFEF00D, 1, 0);
        drive(32'h13FF, 0, 0, 1);
        @(negedge clk) chk("ram_last_word", bus.DataIn_o, 32'hCAFEF00D);
        drive(32'h1400, 0, 0, 1);
        @(negedge clk) chk("ram_past_end", bus.DataIn_o, 32'h0);

        drive(32'h2000, 32'h0000A5A5, 1, 0);
        drive(32'h2000, 0, 0, 1);
        @(negedge clk);
        chk("led_out", {16'h0, led_o}, 32'h0000A5A5);
        chk("led_load", bus.DataIn_o, 32'h0000A5A5);

        drive(32'h2004, 0, 0, 1);
        sw_i = 16'h1234;
        @(negedge clk) chk("sw_cycle0", bus.DataIn_o, 32'h0);
        @(negedge clk) chk("sw_cycle1", bus.DataIn_o, 32'h0);
        @(negedge clk) chk("sw_cycle2", bus.DataIn_o, 32'h00001234);

        drive(32'h200C, 3, 1, 0);
        drive(32'h2010, 3, 1, 0);
        drive(32'h2008, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            chk("tcount_seq", bus.DataIn_o, (i < 4) ? i : 0);
            chk("irq_seq", {31'h0, irq_o}, (i == 4) ? 32'h1 : 32'h0);
        end
        drive(32'h2014, 1, 1, 0);
        drive(32'h2008, 0, 0, 1);
        @(negedge clk);
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);
        chk("tcount_after_clr", bus.DataIn_o, 32'h2);
        drive(32'h2014, 1, 1, 0);
        drive(32'h2014, 0, 0, 1);
        @(negedge clk) chk("irq_clear_race", {31'h0, irq_o}, 32'h1);

        drive(32'h2008, 32'hFFFFFFFE, 1, 0);
        drive(32'h2008, 0, 0, 1);
        @(negedge clk) chk("tcount_ffe", bus.DataIn_o, 32'hFFFFFFFE);
        @(negedge clk) chk("tcount_fff", bus.DataIn_o, 32'hFFFFFFFF);
        @(negedge clk) chk("tcount_wrap", bus.DataIn_o, 32'h0);

        drive(32'h3000, 0, 0, 1);
        @(negedge clk) chk("unmapped_load", bus.DataIn_o, 32'h0);
        drive(32'h3000, 32'h55555555, 1, 0);
        drive(32'h2004, 32'h0000FFFF, 1, 0);
        drive(32'h2004, 0, 0, 1);
        @(negedge clk);
        chk("ro_sw_kept", bus.DataIn_o, 32'h00001234);
        chk("led_kept", {16'h0, led_o}, 32'h0000A5A5);

        drive(32'h2000, 32'h0000FFFF, 1, 0);
        drive(32'h2008, 0, 0, 1);
        @(negedge clk) chk("led_ffff", {16'h0, led_o}, 32'h0000FFFF);
        repeat (3) @(negedge clk);
        chk("irq_before_rst", {31'h0, irq_o}, 32'h1);
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("async_led", {16'h0, led_o}, 32'h0);
        chk("async_irq", {31'h0, irq_o}, 32'h0);
        chk("async_tcount", bus.DataIn_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        drive(32'h1010, 0, 0, 1);
        @(negedge clk) chk("ram_survives_rst", bus.DataIn_o, 32'h11111111);
        drive(32'h2008, 0, 0, 1);
        @(negedge clk) chk("timer_stopped", bus.DataIn_o, 32'h0);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
